// File: rtl/sdram_responder.sv
// SDRAM command-bus responder: decodes host commands, tracks banks,
// and emits per-beat read/write strobes with {bank,row,col} addresses.
module sdram_responder #(
    parameter int ADD_SIZE = 12,
    parameter int BA_SIZE  = 2,
    parameter int COL_SIZE = 8,
    parameter int TRCD     = 2,
    parameter int TRFC     = 7
) (
    input  logic                                  clk0,
    input  logic                                  reset,
    input  logic                                  cs,
    input  logic                                  ras,
    input  logic                                  cas,
    input  logic                                  we,
    input  logic                                  cke,
    input  logic [BA_SIZE-1:0]                    ba,
    input  logic [ADD_SIZE-1:0]                   sadd,
    output logic                                  rd_valid,
    output logic                                  wr_valid,
    output logic [BA_SIZE+ADD_SIZE+COL_SIZE-1:0]  beat_addr,
    output logic                                  busy,
    output logic                                  err,
    output logic [2:0]                            err_code
);

    localparam int NB  = 2 ** BA_SIZE;
    localparam int TCW = $clog2(TRCD + 1);
    localparam int RFW = $clog2(TRFC + 1);

    typedef enum logic [2:0] {
        C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_LMR
    } cmd_e;

    typedef struct packed {
        logic                v;
        logic                rd;
        logic [BA_SIZE-1:0]  ba;
        logic [ADD_SIZE-1:0] row;
        logic [COL_SIZE-1:0] col;
        logic [2:0]          bl;
    } slot_t;

    cmd_e cmd;

    logic [NB-1:0]       open_q, open_d;
    logic [ADD_SIZE-1:0] row_q [NB];
    logic [ADD_SIZE-1:0] row_d [NB];
    logic [TCW-1:0]      trcd_q [NB];
    logic [TCW-1:0]      trcd_d [NB];
    logic [RFW-1:0]      rf_q, rf_d;
    logic [2:0]          bl_q, bl_d;
    logic [2:0]          cl_q, cl_d;

    // Start slots: entry k starts a burst k+1 enabled edges from now
    slot_t               slot_q [3];
    slot_t               slot_d [3];
    slot_t               ns;

    logic                rdv_q, rdv_d;
    logic                wrv_q, wrv_d;
    logic                fp_q, fp_d;
    logic                kill_q, kill_d;
    logic [2:0]          blb_q, blb_d;
    logic [3:0]          rem_q, rem_d;
    logic [BA_SIZE-1:0]  bba_q, bba_d;
    logic [ADD_SIZE-1:0] bro_q, bro_d;
    logic [COL_SIZE-1:0] bcol_q, bcol_d;
    logic                err_q, err_d;
    logic [2:0]          ec_q, ec_d;

    function automatic logic [3:0] bl_len(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Wrap inside the BL-aligned block; full page wraps the whole row
    function automatic logic [COL_SIZE-1:0] nxt_col(
        input logic [COL_SIZE-1:0] c,
        input logic [2:0]          code
    );
        logic [COL_SIZE-1:0] m;
        if (code == 3'd7)
            m = '1;
        else
            m = COL_SIZE'(bl_len(code)) - COL_SIZE'(1);
        return (c & ~m) | ((c + COL_SIZE'(1)) & m);
    endfunction

    always_comb begin
        cmd = C_NOP;
        if (!cs) begin
            case ({ras, cas, we})
                3'b011:  cmd = C_ACT;
                3'b101:  cmd = C_RD;
                3'b100:  cmd = C_WR;
                3'b010:  cmd = C_PRE;
                3'b001:  cmd = C_REF;
                3'b000:  cmd = C_LMR;
                default: cmd = C_NOP;
            endcase
        end
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        trcd_d = trcd_q;
        rf_d   = rf_q;
        bl_d   = bl_q;
        cl_d   = cl_q;
        slot_d = slot_q;
        rdv_d  = rdv_q;
        wrv_d  = wrv_q;
        fp_d   = fp_q;
        kill_d = kill_q;
        blb_d  = blb_q;
        rem_d  = rem_q;
        bba_d  = bba_q;
        bro_d  = bro_q;
        bcol_d = bcol_q;
        err_d  = 1'b0;
        ec_d   = ec_q;
        ns     = '0;

        if (cke) begin
            for (int i = 0; i < NB; i++)
                if (trcd_q[i] != '0)
                    trcd_d[i] = trcd_q[i] - TCW'(1);
            if (rf_q != '0)
                rf_d = rf_q - RFW'(1);

            slot_d[0] = slot_q[1];
            slot_d[1] = slot_q[2];
            slot_d[2] = '0;

            if (slot_q[0].v) begin
                rdv_d  = slot_q[0].rd;
                wrv_d  = !slot_q[0].rd;
                bba_d  = slot_q[0].ba;
                bro_d  = slot_q[0].row;
                bcol_d = slot_q[0].col;
                blb_d  = slot_q[0].bl;
                fp_d   = (slot_q[0].bl == 3'd7);
                rem_d  = bl_len(slot_q[0].bl) - 4'd1;
            end else if ((rdv_q || wrv_q) && !kill_q
                         && (fp_q || rem_q != 4'd0)) begin
                bcol_d = nxt_col(bcol_q, blb_q);
                if (!fp_q)
                    rem_d = rem_q - 4'd1;
            end else begin
                rdv_d = 1'b0;
                wrv_d = 1'b0;
            end
            kill_d = 1'b0;

            if (cmd != C_NOP && rf_q != '0) begin
                err_d = 1'b1;
                ec_d  = 3'd4;
            end else begin
                case (cmd)
                    C_ACT: begin
                        if (open_q[ba]) begin
                            err_d = 1'b1;
                            ec_d  = 3'd3;
                        end else begin
                            open_d[ba] = 1'b1;
                            row_d[ba]  = sadd;
                            trcd_d[ba] = TCW'(TRCD - 1);
                        end
                    end
                    C_RD, C_WR: begin
                        if (!open_q[ba]) begin
                            err_d = 1'b1;
                            ec_d  = 3'd1;
                        end else if (trcd_q[ba] != '0) begin
                            err_d = 1'b1;
                            ec_d  = 3'd2;
                        end else begin
                            ns.v   = 1'b1;
                            ns.rd  = (cmd == C_RD);
                            ns.ba  = ba;
                            ns.row = row_q[ba];
                            ns.col = sadd[COL_SIZE-1:0];
                            ns.bl  = bl_q;
                            if (cmd == C_WR)
                                slot_d[0] = ns;
                            else if (cl_q == 3'd3)
                                slot_d[2] = ns;
                            else
                                slot_d[1] = ns;
                        end
                    end
                    C_PRE: begin
                        if (sadd[10])
                            open_d = '0;
                        else
                            open_d[ba] = 1'b0;
                        kill_d = (rdv_d || wrv_d)
                                 && (sadd[10] || bba_d == ba);
                    end
                    C_REF: begin
                        if (open_q != '0) begin
                            err_d = 1'b1;
                            ec_d  = 3'd6;
                        end else begin
                            rf_d = RFW'(TRFC);
                        end
                    end
                    C_LMR: begin
                        if ((sadd[2:0] >= 3'd4 && sadd[2:0] <= 3'd6)
                            || (sadd[6:4] != 3'd2 && sadd[6:4] != 3'd3)) begin
                            err_d = 1'b1;
                            ec_d  = 3'd5;
                        end else begin
                            bl_d = sadd[2:0];
                            cl_d = sadd[6:4];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            open_q <= '0;
            rf_q   <= '0;
            bl_q   <= 3'd0;
            cl_q   <= 3'd2;
            for (int i = 0; i < NB; i++) begin
                row_q[i]  <= '0;
                trcd_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++)
                slot_q[i] <= '0;
            rdv_q  <= 1'b0;
            wrv_q  <= 1'b0;
            fp_q   <= 1'b0;
            kill_q <= 1'b0;
            blb_q  <= 3'd0;
            rem_q  <= 4'd0;
            bba_q  <= '0;
            bro_q  <= '0;
            bcol_q <= '0;
            err_q  <= 1'b0;
            ec_q   <= 3'd0;
        end else begin
            open_q <= open_d;
            rf_q   <= rf_d;
            bl_q   <= bl_d;
            cl_q   <= cl_d;
            row_q  <= row_d;
            trcd_q <= trcd_d;
            slot_q <= slot_d;
            rdv_q  <= rdv_d;
            wrv_q  <= wrv_d;
            fp_q   <= fp_d;
            kill_q <= kill_d;
            blb_q  <= blb_d;
            rem_q  <= rem_d;
            bba_q  <= bba_d;
            bro_q  <= bro_d;
            bcol_q <= bcol_d;
            err_q  <= err_d;
            ec_q   <= ec_d;
        end
    end

    assign rd_valid  = rdv_q;
    assign wr_valid  = wrv_q;
    assign beat_addr = {bba_q, bro_q, bcol_q};
    assign busy      = (rf_q != '0);
    assign err       = err_q;
    assign err_code  = ec_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus random command
// traffic, checked against a time-indexed burst schedule model.
module tb_sdram_responder;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] DES = 4'b1111;
    localparam int TRCD = 2;
    localparam int TRFC = 7;
    localparam int BIG  = 32'h3fffffff;

    logic        clk0 = 1'b0;
    logic        reset, cs, ras, cas, we, cke;
    logic [1:0]  ba;
    logic [11:0] sadd;
    logic        rd_valid, wr_valid, busy, err;
    logic [21:0] beat_addr;
    logic [2:0]  err_code;

    sdram_responder dut (
        .clk0(clk0), .reset(reset), .cs(cs), .ras(ras), .cas(cas),
        .we(we), .cke(cke), .ba(ba), .sadd(sadd),
        .rd_valid(rd_valid), .wr_valid(wr_valid),
        .beat_addr(beat_addr), .busy(busy), .err(err),
        .err_code(err_code)
    );

    always #5 clk0 = ~clk0;

    typedef struct {
        int st;
        int stop;
        bit rd;
        int ba;
        int row;
        int col;
        int bl;
    } burst_t;

    burst_t bq[$];
    int     now;
    bit     m_open[4];
    int     m_row[4];
    int     m_act[4];
    int     busy_end;
    int     m_bl, m_cl;
    int     e_rd, e_wr, e_busy, e_err, e_ec, e_addr;
    int     nvec, nmis;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int blen(input int c);
        case (c)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int cur_idx(input int t);
        int best = -1;
        foreach (bq[i])
            if (bq[i].st <= t && (best < 0 || bq[i].st > bq[best].st))
                best = i;
        return best;
    endfunction

    // Beat k of a burst: full page counts modulo the row, otherwise
    // the low bits count modulo BL inside the aligned block
    task automatic expect_at(input int t);
        int idx, k, len, col, m;
        burst_t b;
        e_rd = 0;
        e_wr = 0;
        e_addr = 0;
        idx = cur_idx(t);
        if (idx >= 0) begin
            b = bq[idx];
            k = t - b.st;
            len = blen(b.bl);
            if (t <= b.stop && (b.bl == 7 || k < len)) begin
                if (b.bl == 7) begin
                    col = (b.col + k) % 256;
                end else begin
                    m = len - 1;
                    col = (b.col & ~m) | ((b.col + k) & m);
                end
                e_rd = b.rd ? 1 : 0;
                e_wr = b.rd ? 0 : 1;
                e_addr = (b.ba << 20) | (b.row << 8) | col;
            end
            for (int i = bq.size() - 1; i >= 0; i--)
                if (bq[i].st < b.st)
                    bq.delete(i);
        end
    endtask

    task automatic model(input bit k, input bit r, input logic [3:0] c,
                         input int b, input int a);
        int  idx, st;
        bit  nop;
        logic [2:0] op;
        if (r) begin
            bq.delete();
            for (int i = 0; i < 4; i++) m_open[i] = 0;
            busy_end = -100;
            m_bl = 0;
            m_cl = 2;
            e_rd = 0; e_wr = 0; e_busy = 0; e_err = 0; e_ec = 0;
            e_addr = 0;
            return;
        end
        if (!k) begin
            e_err = 0;
            return;
        end
        now++;
        e_err = 0;
        op = c[2:0];
        nop = c[3] || op == 3'b111 || op == 3'b110;
        if (!nop && (now - 1) < busy_end) begin
            e_err = 1; e_ec = 4;
        end else if (!nop) begin
            case (op)
                3'b011: begin
                    if (m_open[b]) begin
                        e_err = 1; e_ec = 3;
                    end else begin
                        m_open[b] = 1;
                        m_row[b] = a;
                        m_act[b] = now;
                    end
                end
                3'b101, 3'b100: begin
                    if (!m_open[b]) begin
                        e_err = 1; e_ec = 1;
                    end else if (now - m_act[b] < TRCD) begin
                        e_err = 1; e_ec = 2;
                    end else begin
                        st = now + ((op == 3'b101) ? m_cl : 1);
                        for (int i = bq.size() - 1; i >= 0; i--)
                            if (bq[i].st == st) bq.delete(i);
                        bq.push_back('{st, BIG, op == 3'b101, b,
                                       m_row[b], a % 256, m_bl});
                    end
                end
                3'b010: begin
                    idx = cur_idx(now);
                    if (idx >= 0 && (a[10] || bq[idx].ba == b)
                        && bq[idx].stop > now)
                        bq[idx].stop = now;
                    for (int i = 0; i < 4; i++)
                        if (a[10] || i == b) m_open[i] = 0;
                end
                3'b001: begin
                    if (m_open[0] || m_open[1] || m_open[2] || m_open[3])
                    begin
                        e_err = 1; e_ec = 6;
                    end else begin
                        busy_end = now + TRFC;
                    end
                end
                default: begin
                    if ((a % 8 >= 4 && a % 8 <= 6)
                        || ((a >> 4) % 8 != 2 && (a >> 4) % 8 != 3)) begin
                        e_err = 1; e_ec = 5;
                    end else begin
                        m_bl = a % 8;
                        m_cl = (a >> 4) % 8;
                    end
                end
            endcase
        end
        expect_at(now);
        e_busy = (now < busy_end) ? 1 : 0;
    endtask

    task automatic step(input bit k, input bit r, input logic [3:0] c,
                        input int b, input int a);
        cke = k;
        reset = r;
        {cs, ras, cas, we} = c;
        ba = b[1:0];
        sadd = a[11:0];
        model(k, r, c, b, a);
        @(posedge clk0);
        @(negedge clk0);
        check("rd_valid", 32'(rd_valid), e_rd);
        check("wr_valid", 32'(wr_valid), e_wr);
        check("busy", 32'(busy), e_busy);
        check("err", 32'(err), e_err);
        check("err_code", 32'(err_code), e_ec);
        if (e_rd != 0 || e_wr != 0)
            check("beat_addr", 32'(beat_addr), e_addr);
    endtask

    task automatic cmd(input logic [3:0] c, input int b, input int a);
        step(1'b1, 1'b0, c, b, a);
    endtask

    initial begin
        int cols[4];
        int r, b, a;
        cols = '{6, 7, 4, 5};
        nvec = 0;
        nmis = 0;
        now = 0;
        reset = 1'b1;
        cke = 1'b1;
        {cs, ras, cas, we} = NOP;
        ba = '0;
        sadd = '0;
        @(negedge clk0);
        step(1'b1, 1'b1, NOP, 0, 0);
        step(1'b0, 1'b1, RD, 1, 0);

        // LOAD MODE BL=4 CL=3, then read at col 6
        cmd(LMR, 0, 12'h032);
        cmd(ACT, 1, 12'h155);
        cmd(NOP, 0, 0);
        cmd(NOP, 0, 0);
        cmd(RD, 1, 12'h006);
        for (int i = 1; i <= 7; i++) begin
            cmd(NOP, 0, 0);
            check("dir_rd", 32'(rd_valid), (i >= 3 && i <= 6) ? 1 : 0);
            if (i >= 3 && i <= 6)
                check("dir_addr", 32'(beat_addr),
                      (1 << 20) | (12'h155 << 8) | cols[i-3]);
        end

        // write too soon after ACTIVE
        cmd(ACT, 2, 12'h0AA);
        cmd(WR, 2, 12'h010);
        check("dir_trcd_err", {29'd0, err_code}, 32'd2);
        cmd(NOP, 0, 0);

        // full-page write wrapping, stopped by PRECHARGE
        cmd(LMR, 0, 12'h027);
        cmd(WR, 1, 12'h0FE);
        for (int i = 0; i < 4; i++) cmd(NOP, 0, 0);
        cmd(PRE, 1, 0);
        for (int i = 0; i < 3; i++) cmd(NOP, 0, 0);

        // refresh and a command while busy
        cmd(PRE, 0, 12'h400);
        cmd(REF, 0, 0);
        cmd(ACT, 0, 12'h001);
        for (int i = 0; i < 8; i++) cmd(NOP, 0, 0);

        // truncation, cke pause, reset mid-burst
        cmd(LMR, 0, 12'h032);
        cmd(ACT, 3, 12'h3C3);
        cmd(NOP, 0, 0);
        cmd(RD, 3, 12'h000);
        cmd(NOP, 0, 0);
        cmd(RD, 3, 12'h008);
        for (int i = 0; i < 6; i++) cmd(NOP, 0, 0);
        cmd(WR, 3, 12'h004);
        cmd(NOP, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, NOP, 0, 0);
        cmd(NOP, 0, 0);
        step(1'b1, 1'b1, NOP, 0, 0);
        check("dir_rst_wr", 32'(wr_valid), 0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            b = $urandom_range(0, 3);
            a = $urandom_range(0, 4095);
            if (r < 1)
                step(1'b1, 1'b1, NOP, b, a);
            else if (r < 6)
                step(1'b0, 1'b0, 4'($urandom_range(0, 15)), b, a);
            else if (r < 34) cmd(NOP, b, a);
            else if (r < 50) cmd(ACT, b, a);
            else if (r < 65) cmd(RD, b, a);
            else if (r < 78) cmd(WR, b, a);
            else if (r < 87)
                cmd(PRE, b, ($urandom_range(0, 3) == 0) ? 12'h400 : 0);
            else if (r < 90) cmd(REF, b, a);
            else if (r < 96) begin
                a = $urandom_range(0, 7);
                if (a >= 4 && a <= 6 && $urandom_range(0, 1) == 1) a = 7;
                a = a | (($urandom_range(0, 5) == 0
                          ? $urandom_range(0, 7) : $urandom_range(2, 3)) << 4);
                cmd(LMR, b, a);
            end else cmd(DES, b, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
